time_setter: RTL and testbench

TIME_SETTER -- requirements
Module: time_setter

---
 rtl/time_setter_if.sv | 31 +++
 rtl/time_setter.sv | 132 +++++++++++++
 tb/tb_time_setter.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/time_setter_if.sv
// Button, live-time and shadow-time bundle between the clock/counter chain and time_setter.
interface time_setter_if;
   logic        btn_mode;
   logic        btn_inc;
   logic        btn_dec;
   logic [5:0]  sec;
   logic [5:0]  min;
   logic [4:0]  hour;
   logic [4:0]  day;
   logic [3:0]  mont;
   logic [12:0] year;
   logic        set_active;
   logic [2:0]  field;
   logic        load;
   logic [5:0]  set_sec;
   logic [5:0]  set_min;
   logic [4:0]  set_hour;
   logic [4:0]  set_day;
   logic [3:0]  set_mont;
   logic [12:0] set_year;

   modport master (
      output btn_mode, btn_inc, btn_dec, sec, min, hour, day, mont, year,
      input  set_active, field, load, set_sec, set_min, set_hour, set_day, set_mont, set_year
   );

   modport slave (
      input  btn_mode, btn_inc, btn_dec, sec, min, hour, day, mont, year,
      output set_active, field, load, set_sec, set_min, set_hour, set_day, set_mont, set_year
   );
endinterface

// File: rtl/time_setter.sv
// Button-driven time/date editor: captures live time, edits fields, then strobes load once.
// Define TIME_SET_DEC_EN to make btn_dec decrement the current field.
module time_setter (
   input logic          clk_1Hz,
   input logic          rst_n,
   time_setter_if.slave bus
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] E_HOUR = 3'd1;
   localparam logic [2:0] E_MIN  = 3'd2;
   localparam logic [2:0] E_DAY  = 3'd3;
   localparam logic [2:0] E_MONT = 3'd4;
   localparam logic [2:0] E_YEAR = 3'd5;
   localparam logic [2:0] COMMIT = 3'd6;

   logic [2:0]  state;
   logic [5:0]  sh_sec;
   logic [5:0]  sh_min;
   logic [4:0]  sh_hour;
   logic [4:0]  sh_day;
   logic [3:0]  sh_mont;
   logic [12:0] sh_year;
   logic        step_up;
   logic        step_dn;
   logic [4:0]  mday;

   function automatic logic [4:0] max_day(input logic [3:0] m, input logic [12:0] y);
      case (m)
         4'd2:                   return (y[1:0] == 2'b00) ? 5'd29 : 5'd28;
         4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
         default:                return 5'd31;
      endcase
   endfunction

   function automatic logic [12:0] sanitize(input logic [12:0] v, input logic [12:0] lo,
                                            input logic [12:0] hi);
      return (v < lo || v > hi) ? lo : v;
   endfunction

   function automatic logic [12:0] wrap_inc(input logic [12:0] v, input logic [12:0] lo,
                                            input logic [12:0] hi);
      return (v >= hi) ? lo : v + 13'd1;
   endfunction

   function automatic logic [12:0] wrap_dec(input logic [12:0] v, input logic [12:0] lo,
                                            input logic [12:0] hi);
      return (v <= lo) ? hi : v - 13'd1;
   endfunction

`ifdef TIME_SET_DEC_EN
   // Simultaneous inc and dec cancel out.
   assign step_up = bus.btn_inc & ~bus.btn_dec;
   assign step_dn = bus.btn_dec & ~bus.btn_inc;
`else
   logic unused_dec;
   assign unused_dec = bus.btn_dec;
   assign step_up    = bus.btn_inc;
   assign step_dn    = 1'b0;
`endif

   assign mday = max_day(sh_mont, sh_year);

   always_ff @(posedge clk_1Hz or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         sh_sec  <= 6'd0;
         sh_min  <= 6'd0;
         sh_hour <= 5'd0;
         sh_day  <= 5'd1;
         sh_mont <= 4'd1;
         sh_year <= 13'd2000;
      end else begin
         case (state)
            IDLE: begin
               if (bus.btn_mode) begin
                  sh_sec  <= 6'(sanitize(13'(bus.sec), 13'd0, 13'd59));
                  sh_min  <= 6'(sanitize(13'(bus.min), 13'd0, 13'd59));
                  sh_hour <= 5'(sanitize(13'(bus.hour), 13'd0, 13'd23));
                  sh_day  <= 5'(sanitize(13'(bus.day), 13'd1, 13'd31));
                  sh_mont <= 4'(sanitize(13'(bus.mont), 13'd1, 13'd12));
                  sh_year <= sanitize(bus.year, 13'd2000, 13'd2099);
                  state   <= E_HOUR;
               end
            end
            E_HOUR: begin
               if (bus.btn_mode)  state   <= E_MIN;
               else if (step_up)  sh_hour <= 5'(wrap_inc(13'(sh_hour), 13'd0, 13'd23));
               else if (step_dn)  sh_hour <= 5'(wrap_dec(13'(sh_hour), 13'd0, 13'd23));
            end
            E_MIN: begin
               if (bus.btn_mode)  state  <= E_DAY;
               else if (step_up)  sh_min <= 6'(wrap_inc(13'(sh_min), 13'd0, 13'd59));
               else if (step_dn)  sh_min <= 6'(wrap_dec(13'(sh_min), 13'd0, 13'd59));
            end
            E_DAY: begin
               if (bus.btn_mode)  state  <= E_MONT;
               else if (step_up)  sh_day <= 5'(wrap_inc(13'(sh_day), 13'd1, 13'(mday)));
               else if (step_dn)  sh_day <= 5'(wrap_dec(13'(sh_day), 13'd1, 13'(mday)));
            end
            E_MONT: begin
               if (bus.btn_mode)  state   <= E_YEAR;
               else if (step_up)  sh_mont <= 4'(wrap_inc(13'(sh_mont), 13'd1, 13'd12));
               else if (step_dn)  sh_mont <= 4'(wrap_dec(13'(sh_mont), 13'd1, 13'd12));
            end
            E_YEAR: begin
               // Day is only reconciled with month/year here, so intermediate edits never lose it.
               if (bus.btn_mode) begin
                  state  <= COMMIT;
                  sh_sec <= 6'd0;
                  if (sh_day > mday) sh_day <= mday;
               end
               else if (step_up)  sh_year <= wrap_inc(sh_year, 13'd2000, 13'd2099);
               else if (step_dn)  sh_year <= wrap_dec(sh_year, 13'd2000, 13'd2099);
            end
            COMMIT:  state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.set_active = (state >= E_HOUR) && (state <= E_YEAR);
   assign bus.field      = (state == COMMIT) ? 3'd0 : state;
   assign bus.load       = (state == COMMIT);
   assign bus.set_sec    = sh_sec;
   assign bus.set_min    = sh_min;
   assign bus.set_hour   = sh_hour;
   assign bus.set_day    = sh_day;
   assign bus.set_mont   = sh_mont;
   assign bus.set_year   = sh_year;

endmodule

// File: tb/tb_time_setter.sv
// Directed bench for time_setter: capture, edit, wrap, day clamp, priority and reset abandonment.
module tb_time_setter;

`ifdef TIME_SET_DEC_EN
   localparam bit DEC_EN = 1'b1;
`else
   localparam bit DEC_EN = 1'b0;
`endif

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;
   int   load_cnt;
   int   load_mark;

   time_setter_if bus ();

   time_setter dut (
      .clk_1Hz (clk),
      .rst_n   (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (bus.load === 1'b1) load_cnt++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic set_live(input int h, input int m, input int s,
                           input int d, input int mo, input int y);
      bus.hour = 5'(h);
      bus.min  = 6'(m);
      bus.sec  = 6'(s);
      bus.day  = 5'(d);
      bus.mont = 4'(mo);
      bus.year = 13'(y);
   endtask

   // Called at a falling edge; returns at the next falling edge with the result visible.
   task automatic press(input bit m, input bit i, input bit d);
      bus.btn_mode = m;
      bus.btn_inc  = i;
      bus.btn_dec  = d;
      @(posedge clk);
      #1;
      bus.btn_mode = 1'b0;
      bus.btn_inc  = 1'b0;
      bus.btn_dec  = 1'b0;
      @(negedge clk);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_active"}, 32'(bus.set_active), 32'd0);
      chk({tag, "_field"},  32'(bus.field),      32'd0);
      chk({tag, "_load"},   32'(bus.load),       32'd0);
      chk({tag, "_sec"},    32'(bus.set_sec),    32'd0);
      chk({tag, "_min"},    32'(bus.set_min),    32'd0);
      chk({tag, "_hour"},   32'(bus.set_hour),   32'd0);
      chk({tag, "_day"},    32'(bus.set_day),    32'd1);
      chk({tag, "_mont"},   32'(bus.set_mont),   32'd1);
      chk({tag, "_year"},   32'(bus.set_year),   32'd2000);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      load_cnt = 0;
      bus.btn_mode = 1'b0;
      bus.btn_inc  = 1'b0;
      bus.btn_dec  = 1'b0;
      set_live(10, 20, 30, 15, 5, 2024);
      rst_n = 1'b0;
      #12;
      check_reset_vals("rst");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Inc in IDLE is ignored
      press(0, 1, 0);
      chk("idle_inc_field", 32'(bus.field), 32'd0);
      chk("idle_inc_hour",  32'(bus.set_hour), 32'd0);

      // Basic edit of 10:20:30 2024-05-15
      load_mark = load_cnt;
      press(1, 0, 0);
      chk("cap_field",  32'(bus.field), 32'd1);
      chk("cap_active", 32'(bus.set_active), 32'd1);
      chk("cap_hour",   32'(bus.set_hour), 32'd10);
      chk("cap_sec",    32'(bus.set_sec), 32'd30);
      for (int k = 0; k < 3; k++) press(0, 1, 0);
      chk("inc_hour", 32'(bus.set_hour), 32'd13);
      for (int k = 0; k < 4; k++) press(1, 0, 0);
      chk("at_year_field", 32'(bus.field), 32'd5);
      chk("at_year_load",  32'(bus.load), 32'd0);
      press(1, 0, 0);
      chk("commit_load",   32'(bus.load), 32'd1);
      chk("commit_field",  32'(bus.field), 32'd0);
      chk("commit_active", 32'(bus.set_active), 32'd0);
      chk("commit_sec",    32'(bus.set_sec), 32'd0);
      chk("commit_hour",   32'(bus.set_hour), 32'd13);
      chk("commit_min",    32'(bus.set_min), 32'd20);
      chk("commit_day",    32'(bus.set_day), 32'd15);
      chk("commit_mont",   32'(bus.set_mont), 32'd5);
      chk("commit_year",   32'(bus.set_year), 32'd2024);
      @(negedge clk);
      chk("post_load",  32'(bus.load), 32'd0);
      chk("post_field", 32'(bus.field), 32'd0);
      chk("post_hold",  32'(bus.set_hour), 32'd13);
      chk("load_once",  32'(load_cnt - load_mark), 32'd1);

      // Day clamp on Jan 31 -> Feb, non-leap then leap
      for (int pass = 0; pass < 2; pass++) begin
         set_live(8, 0, 0, 31, 1, (pass == 0) ? 2023 : 2024);
         for (int k = 0; k < 4; k++) press(1, 0, 0);
         press(0, 1, 0);
         chk("feb_mont", 32'(bus.set_mont), 32'd2);
         press(1, 0, 0);
         chk("feb_day_unclamped", 32'(bus.set_day), 32'd31);
         press(1, 0, 0);
         chk("feb_load", 32'(bus.load), 32'd1);
         chk("feb_day", 32'(bus.set_day), (pass == 0) ? 32'd28 : 32'd29);
         @(negedge clk);
      end

      // Wrap at maxima from 23:59 2099-12-31
      set_live(23, 59, 0, 31, 12, 2099);
      press(1, 0, 0);
      press(0, 1, 0);
      chk("wrap_hour", 32'(bus.set_hour), 32'd0);
      press(1, 0, 0);
      press(0, 1, 0);
      chk("wrap_min", 32'(bus.set_min), 32'd0);
      press(1, 0, 0);
      press(0, 1, 0);
      chk("wrap_day", 32'(bus.set_day), 32'd1);
      press(1, 0, 0);
      press(0, 1, 0);
      chk("wrap_mont", 32'(bus.set_mont), 32'd1);
      press(1, 0, 0);
      press(0, 1, 0);
      chk("wrap_year", 32'(bus.set_year), 32'd2000);
      press(1, 0, 0);
      chk("wrap_commit_load", 32'(bus.load), 32'd1);
      @(negedge clk);

      // Out-of-range live values are captured as range minimums
      set_live(25, 61, 63, 0, 13, 1999);
      load_mark = load_cnt;
      press(1, 0, 0);
      chk("oor_hour", 32'(bus.set_hour), 32'd0);
      chk("oor_min",  32'(bus.set_min), 32'd0);
      chk("oor_sec",  32'(bus.set_sec), 32'd0);
      chk("oor_day",  32'(bus.set_day), 32'd1);
      chk("oor_mont", 32'(bus.set_mont), 32'd1);
      chk("oor_year", 32'(bus.set_year), 32'd2000);

      // Mode beats inc in E_MIN, then reset abandons edit in E_DAY
      press(1, 0, 0);
      press(1, 1, 0);
      chk("prio_field", 32'(bus.field), 32'd3);
      chk("prio_min",   32'(bus.set_min), 32'd0);
      press(0, 1, 0);
      chk("eday_inc", 32'(bus.set_day), 32'd2);
      rst_n = 1'b0;
      #1;
      check_reset_vals("rst_edit");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_no_load", 32'(load_cnt - load_mark), 32'd0);

      // First mode after reset captures again
      set_live(10, 20, 30, 15, 5, 2024);
      press(1, 0, 0);
      chk("recap_field", 32'(bus.field), 32'd1);
      chk("recap_hour",  32'(bus.set_hour), 32'd10);

      // Decrement behaviour in E_DAY for April 1
      set_live(9, 0, 0, 1, 4, 2024);
      for (int k = 0; k < 5; k++) press(1, 0, 0);
      @(negedge clk);
      press(1, 0, 0);
      press(1, 0, 0);
      press(1, 0, 0);
      chk("dec_field", 32'(bus.field), 32'd3);
      press(0, 0, 1);
      chk("dec_day", 32'(bus.set_day), DEC_EN ? 32'd30 : 32'd1);
      press(0, 1, 1);
      chk("incdec_day", 32'(bus.set_day), DEC_EN ? 32'd30 : 32'd2);
      press(1, 0, 0);
      press(1, 0, 0);
      press(1, 0, 0);
      chk("dec_commit_load", 32'(bus.load), 32'd1);

      // Reset asserted during COMMIT drops load immediately
      rst_n = 1'b0;
      #1;
      check_reset_vals("rst_commit");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_commit_idle", 32'(bus.field), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
